// File: rtl/ram_arbiter_np.sv
// ram_arbiter_np
//   N-port front end for a single sp_ram. One access per cycle is granted
//   combinationally (fixed priority or round-robin), driven straight onto the
//   RAM port, and tracked through a RAM_LATENCY-deep {valid, port} pipeline so
//   each response returns to the port that issued it.
//
// Ports
//   clk, rstn                      clock, async active-low reset
//   req_i/addr_i/we_i/be_i/wdata_i per-port request bundle, port p at slice p
//   gnt_o                          per-port grant, one-hot or zero
//   rvalid_o/rdata_o               per-port response, RAM_LATENCY after grant
//   ram_*_o                        access to sp_ram, all zero when idle
//   ram_rdata_i                    sp_ram read data
module ram_arbiter_np #(
   parameter int NUM_PORTS   = 2,
   parameter int ADDR_WIDTH  = 22,
   parameter int DATA_WIDTH  = 32,
   parameter int RAM_LATENCY = 1,
   parameter int ARB_MODE    = 0
) (
   input  logic                              clk,
   input  logic                              rstn,
   input  logic [NUM_PORTS-1:0]              req_i,
   input  logic [NUM_PORTS*ADDR_WIDTH-1:0]   addr_i,
   input  logic [NUM_PORTS-1:0]              we_i,
   input  logic [NUM_PORTS*DATA_WIDTH/8-1:0] be_i,
   input  logic [NUM_PORTS*DATA_WIDTH-1:0]   wdata_i,
   output logic [NUM_PORTS-1:0]              gnt_o,
   output logic [NUM_PORTS-1:0]              rvalid_o,
   output logic [NUM_PORTS*DATA_WIDTH-1:0]   rdata_o,
   output logic                              ram_en_o,
   output logic [ADDR_WIDTH-1:0]             ram_addr_o,
   output logic                              ram_we_o,
   output logic [DATA_WIDTH/8-1:0]           ram_be_o,
   output logic [DATA_WIDTH-1:0]             ram_wdata_o,
   input  logic [DATA_WIDTH-1:0]             ram_rdata_i
);

   localparam int IDX_W = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
   localparam int BE_W  = DATA_WIDTH / 8;

   logic [IDX_W-1:0]       r_ptr;
   logic [IDX_W-1:0]       w_start;
   logic [IDX_W-1:0]       w_cand;
   logic [IDX_W-1:0]       w_gnt_idx;
   logic                   w_gnt_vld;
   int                     w_sum;
   logic [RAM_LATENCY-1:0] r_pipe_vld;
   logic [IDX_W-1:0]       r_pipe_idx [RAM_LATENCY];

   // Fixed priority is round-robin with the search always starting at port 0.
   assign w_start = (ARB_MODE == 1) ? r_ptr : '0;

   // Search wraps explicitly at NUM_PORTS so non-power-of-two counts work.
   always_comb begin
      w_gnt_vld = 1'b0;
      w_gnt_idx = '0;
      w_cand    = '0;
      w_sum     = 0;
      for (int off = 0; off < NUM_PORTS; off++) begin
         w_sum = int'(w_start) + off;
         if (w_sum >= NUM_PORTS) begin
            w_sum = w_sum - NUM_PORTS;
         end
         w_cand = IDX_W'(w_sum);
         if (!w_gnt_vld && req_i[w_cand]) begin
            w_gnt_vld = 1'b1;
            w_gnt_idx = w_cand;
         end
      end
      // No grant may leak out while reset is held, even with requests pending.
      if (!rstn) begin
         w_gnt_vld = 1'b0;
      end
   end

   always_comb begin
      gnt_o       = '0;
      ram_en_o    = 1'b0;
      ram_addr_o  = '0;
      ram_we_o    = 1'b0;
      ram_be_o    = '0;
      ram_wdata_o = '0;
      for (int p = 0; p < NUM_PORTS; p++) begin
         if (w_gnt_vld && (w_gnt_idx == IDX_W'(p))) begin
            gnt_o[p]    = 1'b1;
            ram_en_o    = 1'b1;
            ram_addr_o  = addr_i[p*ADDR_WIDTH +: ADDR_WIDTH];
            ram_we_o    = we_i[p];
            ram_be_o    = be_i[p*BE_W +: BE_W];
            ram_wdata_o = wdata_i[p*DATA_WIDTH +: DATA_WIDTH];
         end
      end
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         r_ptr <= '0;
      end else if ((ARB_MODE == 1) && w_gnt_vld) begin
         r_ptr <= (w_gnt_idx == IDX_W'(NUM_PORTS - 1)) ? '0 : w_gnt_idx + IDX_W'(1);
      end
   end

   // Response pipeline never stalls; reset drops anything in flight.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         r_pipe_vld <= '0;
         for (int s = 0; s < RAM_LATENCY; s++) begin
            r_pipe_idx[s] <= '0;
         end
      end else begin
         r_pipe_vld[0] <= w_gnt_vld;
         r_pipe_idx[0] <= w_gnt_idx;
         for (int s = 1; s < RAM_LATENCY; s++) begin
            r_pipe_vld[s] <= r_pipe_vld[s-1];
            r_pipe_idx[s] <= r_pipe_idx[s-1];
         end
      end
   end

   always_comb begin
      rvalid_o = '0;
      rdata_o  = '0;
      for (int p = 0; p < NUM_PORTS; p++) begin
         if (r_pipe_vld[RAM_LATENCY-1] && (r_pipe_idx[RAM_LATENCY-1] == IDX_W'(p))) begin
            rvalid_o[p]                          = 1'b1;
            rdata_o[p*DATA_WIDTH +: DATA_WIDTH]  = ram_rdata_i;
         end
      end
   end

endmodule
